// File: rtl/bcd_countdown_if.sv
// ---------------------------------------------------------------------------
// bcd_countdown_if
// Control/status bundle for the BCD down-counter.
//   master (controller side): drives load, load_value, start, stop, dec;
//                             observes Count, count_eq_0, busy, done.
//   slave  (counter side)   : the reverse.
// Parameter DIGITS sets the number of BCD digits (data width 4*DIGITS).
// ---------------------------------------------------------------------------
interface bcd_countdown_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  start;
    logic                  stop;
    logic                  dec;
    logic [4*DIGITS-1:0]   Count;
    logic                  count_eq_0;
    logic                  busy;
    logic                  done;

    modport master (
        output load, load_value, start, stop, dec,
        input  Count, count_eq_0, busy, done
    );

    modport slave (
        input  load, load_value, start, stop, dec,
        output Count, count_eq_0, busy, done
    );
endinterface

// File: rtl/bcd_countdown.sv
// ---------------------------------------------------------------------------
// bcd_countdown
// Multi-digit BCD down-counter / timer. A loaded BCD value is decremented
// once per dec tick while running; count_eq_0 flags zero and done pulses
// for one cycle on expiry. Digits chain by per-digit borrow.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-low reset
//   bus    - bcd_countdown_if.slave:
//              load, load_value[4*DIGITS-1:0], start, stop, dec  (inputs)
//              Count[4*DIGITS-1:0], count_eq_0, busy, done       (outputs)
//
// Optional feature macro: BCD_COUNTDOWN_RELOAD_EN
//   undefined - one-shot: RUN -> EXPIRED when the count reaches 0.
//   defined   - auto-reload: stays in RUN at 0; the next dec reloads the
//               reload register, giving a period of reload value + 1 ticks.
// ---------------------------------------------------------------------------
module bcd_countdown #(
    parameter int DIGITS = 2
) (
    input  logic              clock,
    input  logic              reset,
    bcd_countdown_if.slave    bus
);
    localparam int W = 4 * DIGITS;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    logic [1:0]   state_reg,  state_next;
    logic [W-1:0] count_reg,  count_next;
    logic [W-1:0] reload_reg, reload_next;
    logic         done_reg,   done_next;

    logic [W-1:0]      sat_value;   // load_value with each digit clamped to 9
    logic [W-1:0]      dec_value;   // count_reg minus one, in BCD
    logic [DIGITS-1:0] borrow;      // borrow into each digit; digit 0 always borrows
    logic              count_zero;

    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] ld_digit;
            logic [3:0] cur_digit;

            assign ld_digit  = bus.load_value[4*gi +: 4];
            assign cur_digit = count_reg[4*gi +: 4];

            assign sat_value[4*gi +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;

            // A borrowed-from digit at 0 wraps to 9 and passes the borrow up;
            // digits above the first non-zero digit see no borrow and hold.
            assign dec_value[4*gi +: 4] = !borrow[gi]         ? cur_digit :
                                          (cur_digit == 4'd0) ? 4'd9      :
                                                                cur_digit - 4'd1;

            if (gi < DIGITS - 1) begin : g_chain
                assign borrow[gi+1] = borrow[gi] & (cur_digit == 4'd0);
            end
        end
    endgenerate

    assign count_zero = (count_reg == '0);

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        done_next   = 1'b0;

        if (bus.load) begin
            count_next  = sat_value;
            reload_next = sat_value;
            state_next  = IDLE;
        end else if (bus.stop && state_reg == RUN) begin
            state_next = IDLE;
        end else if (bus.start && state_reg == IDLE) begin
            if (count_zero) begin
                state_next = EXPIRED;
                done_next  = 1'b1;
            end else begin
                state_next = RUN;
            end
        end else if (bus.dec && state_reg == RUN) begin
            if (!count_zero) begin
                count_next = dec_value;
                if (dec_value == '0) begin
                    done_next = 1'b1;
`ifndef BCD_COUNTDOWN_RELOAD_EN
                    state_next = EXPIRED;
`endif
                end
            end
`ifdef BCD_COUNTDOWN_RELOAD_EN
            else begin
                // Sitting at zero in RUN: start the next period.
                count_next = reload_reg;
                if (reload_reg == '0) begin
                    state_next = EXPIRED;
                end
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            reload_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            done_reg   <= done_next;
        end
    end

    assign bus.Count      = count_reg;
    assign bus.count_eq_0 = count_zero;
    assign bus.busy       = (state_reg == RUN);
    assign bus.done       = done_reg;
endmodule

// File: doc/bcd_countdown.md
# bcd_countdown

Multi-digit BCD down-counter/timer: decrements a loaded BCD value by one on each `dec` tick while running, flags zero, and pulses `done` on expiry. It is the counting-down counterpart of the team's mod-10 up-counter (`count10`). It sits beside it in the display/timer datapath, for countdown displays and for reload-period generation. Digits chain by per-digit borrow, mirroring the up-counter's carry/terminal-count chain.

## Interface
Parameters:
- `DIGITS`, default 2: number of BCD digits; count width is 4*DIGITS.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  load `load_value` into `Count` and the reload register.
- `load_value`  in  4*DIGITS  BCD value; digit 0 in bits [3:0].
- `start`  in  1  begin counting; honored only in IDLE.
- `stop`  in  1  pause; RUN -> IDLE, `Count` held.
- `dec`  in  1  decrement tick (enable, not a clock).
- `Count`  out  4*DIGITS  current BCD count.
- `count_eq_0`  out  1  combinational: high when `Count` == 0.
- `busy`  out  1  high in RUN.
- `done`  out  1  registered one-cycle pulse on expiry.

## Operation
- States: IDLE, RUN, EXPIRED. Reset -> IDLE.
- Priority each cycle: `load` > `stop` > `start` > `dec`.
- `load` (any state):
  - `Count` and the reload register get `load_value`, with any digit > 9 saturated to 9.
  - State -> IDLE; `done` stays 0.
- `stop` in RUN: state -> IDLE, `Count` unchanged. `stop` in any other state has no effect.
- `start` in IDLE:
  - If `Count` != 0: state -> RUN.
  - If `Count` == 0: state -> EXPIRED, `done` pulses.
- `start` in RUN or EXPIRED: ignored.
- `dec` in RUN with `Count` != 0:
  - BCD decrement. Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - Digits above the first non-zero digit are unchanged.
- When a decrement produces `Count` == 0, `done` pulses in the cycle `Count` first reads 0.
  - Without the macro: state -> EXPIRED.
- `dec` in IDLE or EXPIRED: ignored.
- `Count` never holds a non-BCD digit.

## Timing
- Reset (asynchronous, any time, including mid-count): `Count` = 0, reload register = 0, state IDLE, `busy` = 0, `done` = 0, `count_eq_0` = 1.
- `load`, `start`, `stop`, `dec` take effect at the next rising edge; `Count` updates one cycle after `dec`.
- `busy` rises on the edge that samples `start` and falls on the edge that enters IDLE or EXPIRED.
- `done` is high for exactly one cycle per expiry. It coincides with `Count` first reading 0, or with the cycle after `start` at zero.
- `dec` held high continuously decrements once per cycle.
- `load` together with `dec` or `start`: only the load occurs.
- `stop` together with `dec`: no decrement.

## Configuration
- `BCD_COUNTDOWN_RELOAD_EN`
  - Defined (auto-reload):
    - On reaching 0 the state stays RUN.
    - The next `dec` with `Count` == 0 loads the reload register into `Count`, with no `done` on that cycle.
    - Period = reload value + 1 `dec` ticks; `done` pulses once per period.
    - EXPIRED is entered only via `start` at zero or a reload value of 0.
  - Undefined (one-shot): RUN -> EXPIRED on reaching 0; further `dec` is ignored until `load`.

## Test plan
- Reset with `reset`=0 mid-count at `Count`=0x37 -> `Count`=0x00, `busy`=0, `done`=0 immediately, without waiting for a clock edge.
- `load` 0x10, `start`, one `dec` -> `Count`=0x09, with digit-1 borrow; 9 more `dec` -> `Count`=0x00, `done` pulses once, state EXPIRED (one-shot build).
- `load` 0x3F -> `Count`=0x39 (digit saturation); `dec` while IDLE -> `Count` stays 0x39.
- `load` 0x02, `start`, `dec` held high, `stop` asserted on the cycle `Count`=0x01 -> `Count` holds 0x01, `busy`=0. Then `start`, `dec` -> 0x00, `done`=1.
- Build with `BCD_COUNTDOWN_RELOAD_EN`, `load` 0x03, `start`, `dec` held for 8 cycles -> sequence 03,02,01,00,03,02,01,00, `done` on each 00, `busy` stays 1.
- `load` 0x00, `start` -> `done` pulses one cycle later, state EXPIRED; `load` with `dec` in the same cycle -> `Count`=`load_value`, no decrement.
